// File: rtl/painel_pkg.sv
// Shared definitions for the 3-digit status panel scanner.
// Glyphs are 7-bit patterns in segment order {a,b,c,d,e,f,g} (bit 6 = a,
// bit 0 = g), active-high before the pin polarity is applied.
package painel_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b1111110; // abcdef
  localparam logic [6:0] GLYPH_1     = 7'b0110000; // bc
  localparam logic [6:0] GLYPH_2     = 7'b1101101; // abdeg
  localparam logic [6:0] GLYPH_3     = 7'b1111001; // abcdg
  localparam logic [6:0] GLYPH_E     = 7'b1001111; // adefg
  localparam logic [6:0] GLYPH_G     = 7'b1011110; // acdef
  localparam logic [6:0] GLYPH_A     = 7'b1110111; // abcefg
  localparam logic [6:0] GLYPH_DASH  = 7'b0000001; // g
  localparam logic [6:0] GLYPH_F     = 7'b1000111; // aefg
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    SLOT_LEVEL = 2'd0,
    SLOT_MODE  = 2'd1,
    SLOT_INLET = 2'd2
  } slot_t;

  // Per-frame status snapshot.
  typedef struct packed {
    logic h;
    logic m;
    logic l;
    logic erro;
    logic al;
    logic vs;
    logic bs;
    logic ve;
  } status_t;

endpackage

// File: rtl/painel_display_scan_glyph_mux.sv
// glyph_mux: combinational digit-content selection.
// Ports:
//   slot    - digit currently being scanned
//   snap    - status snapshot taken at the start of the frame
//   phaseOn - blink phase (1 = lit); only matters while snap.al is set
//   pattern - active-high segment pattern {a..g}
module glyph_mux
  import painel_pkg::*;
(
  input  slot_t      slot,
  input  status_t    snap,
  input  logic       phaseOn,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = GLYPH_BLANK;
    case (slot)
      SLOT_LEVEL: begin
        if (snap.al && !phaseOn) begin
          pattern = GLYPH_BLANK;
        end else if (snap.erro) begin
          pattern = GLYPH_E;
        end else begin
          // Only the four physically consistent sensor combinations map
          // to a level; anything else is a sensor fault.
          case ({snap.h, snap.m, snap.l})
            3'b111:  pattern = GLYPH_3;
            3'b011:  pattern = GLYPH_2;
            3'b001:  pattern = GLYPH_1;
            3'b000:  pattern = GLYPH_0;
            default: pattern = GLYPH_E;
          endcase
        end
      end
      SLOT_MODE: begin
        if (snap.vs && snap.bs) begin
          pattern = GLYPH_E;
        end else if (snap.vs) begin
          pattern = GLYPH_G;
        end else if (snap.bs) begin
          pattern = GLYPH_A;
        end else begin
          pattern = GLYPH_DASH;
        end
      end
      SLOT_INLET: begin
        pattern = snap.ve ? GLYPH_F : GLYPH_BLANK;
      end
      default: pattern = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/painel_display_scan.sv
// painel_display_scan: multiplexed driver for the 3-digit 7-segment panel.
// Scans one digit per CLK_DIV-cycle slot, takes a status snapshot at the
// start of each frame and blinks the level digit while the alarm is set.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   H, M, L           - tank level sensors
//   Erro, Al          - sensor-fault flag, alarm request
//   Vs, Bs, Ve        - drip valve, sprinkler, inlet valve commands
//   Dig1..Dig3        - digit enables (level, mode, inlet), registered
//   SegA..SegG        - segment outputs, registered
module painel_display_scan
  import painel_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic H,
  input  logic M,
  input  logic L,
  input  logic Erro,
  input  logic Al,
  input  logic Vs,
  input  logic Bs,
  input  logic Ve,
  output logic Dig1,
  output logic Dig2,
  output logic Dig3,
  output logic SegA,
  output logic SegB,
  output logic SegC,
  output logic SegD,
  output logic SegE,
  output logic SegF,
  output logic SegG
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt;
  slot_t            slot;
  slot_t            slotNext;
  logic [FR_W-1:0]  frameCnt;
  logic             phaseOn;
  status_t          snap;
  logic [6:0]       glyph;
  logic [2:0]       digNext;
  logic [6:0]       segNext;
  logic [2:0]       digQ;
  logic [6:0]       segQ;
  logic             cntTerm;
  logic             frameStart;

  assign cntTerm    = (cnt == CNT_W'(CLK_DIV - 1));
  assign frameStart = (slot == SLOT_LEVEL) && (cnt == '0);

  glyph_mux uGlyph (
    .slot    (slot),
    .snap    (snap),
    .phaseOn (phaseOn),
    .pattern (glyph)
  );

  always_comb begin
    slotNext = SLOT_LEVEL;
    digNext  = 3'b000;
    segNext  = GLYPH_BLANK;
    case (slot)
      SLOT_LEVEL: slotNext = SLOT_MODE;
      SLOT_MODE:  slotNext = SLOT_INLET;
      default:    slotNext = SLOT_LEVEL;
    endcase
    // First cycle of each slot is dark so the previous digit's segments
    // never ghost onto the next digit.
    if (cnt != '0) begin
      case (slot)
        SLOT_LEVEL: digNext = 3'b001;
        SLOT_MODE:  digNext = 3'b010;
        SLOT_INLET: digNext = 3'b100;
        default:    digNext = 3'b000;
      endcase
      segNext = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      slot     <= SLOT_LEVEL;
      frameCnt <= '0;
      phaseOn  <= 1'b1;
      snap     <= '0;
      digQ     <= 3'b000;
      segQ     <= GLYPH_BLANK;
    end else begin
      cnt <= cntTerm ? '0 : cnt + CNT_W'(1);
      if (cntTerm) begin
        slot <= slotNext;
      end

      if (frameStart) begin
        snap <= '{h: H, m: M, l: L, erro: Erro, al: Al, vs: Vs, bs: Bs, ve: Ve};
      end

      // Blink timebase only runs while the snapshot carries the alarm, so
      // every alarm episode starts with a full lit half-period.
      if (!snap.al) begin
        frameCnt <= '0;
        phaseOn  <= 1'b1;
      end else if (cntTerm && (slot == SLOT_INLET)) begin
        if (frameCnt == FR_W'(BLINK_FRAMES - 1)) begin
          frameCnt <= '0;
          phaseOn  <= ~phaseOn;
        end else begin
          frameCnt <= frameCnt + FR_W'(1);
        end
      end

      digQ <= digNext;
      segQ <= segNext;
    end
  end

  assign Dig1 = digQ[0] ^ DIG_ACTIVE_LOW;
  assign Dig2 = digQ[1] ^ DIG_ACTIVE_LOW;
  assign Dig3 = digQ[2] ^ DIG_ACTIVE_LOW;
  assign {SegA, SegB, SegC, SegD, SegE, SegF, SegG} = segQ ^ {7{SEG_ACTIVE_LOW}};

endmodule
